// File: rtl/store_writer.sv
// -----------------------------------------------------------------------------
// store_writer
//
// Write-back stage for the row-reduction pipeline. Single-cycle store pulses
// are buffered in an internal FIFO and issued as sequential 64-bit memory
// write requests, starting at a base address latched on start. The address
// advances by 8 per write and wraps silently at 2^ADDR_W.
//
// Optional feature (compile-time macro STORE_WRITER_COUNT_EN):
//   adds output written_count[31:0], a saturating count of completed writes
//   for the current run, cleared on reset and on the start that enters RUN.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle pulse; latches base_addr and begins a run
//   base_addr    in   first write address (8-byte aligned)
//   store        in   result valid, one beat per cycle, no ready
//   store_value  in   64-bit result data
//   flush        in   no further stores follow; drain and finish
//   stall_out    out  registered; high when free entries <= STALL_MARGIN
//   mem_req      out  write request valid
//   mem_addr     out  write address
//   mem_data     out  write data
//   mem_stall    in   memory not accepting this cycle
//   done         out  run complete (level)
//   err          out  sticky; a store was dropped
//   written_count out (STORE_WRITER_COUNT_EN only) completed write count
// -----------------------------------------------------------------------------
module store_writer #(
    parameter int unsigned ADDR_W       = 48,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned STALL_MARGIN = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              store,
    input  logic [63:0]       store_value,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_data,
    input  logic              mem_stall,
    output logic              done,
    output logic              err
`ifdef STORE_WRITER_COUNT_EN
    ,
    output logic [31:0]       written_count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(STALL_MARGIN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            r_state;

    // FIFO storage and bookkeeping
    logic [63:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Next address to be assigned to an entry leaving the FIFO
    logic [ADDR_W-1:0] r_addr;

    // Registered outputs
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [63:0]       r_mem_data;
    logic              r_stall_out;
    logic              r_done;
    logic              r_err;

    logic              w_accepting;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_xfer;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_free;

    assign w_accepting = (r_state == RUN) || (r_state == DRAIN);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == DEPTH_C);
    assign w_xfer      = r_mem_req && !mem_stall;

    // The output register only reloads while the memory is not stalling:
    // either it is idle (mem_req=0) or its current beat completes this edge.
    // This keeps mem_req/mem_addr/mem_data frozen for the whole stall.
    assign w_pop       = !mem_stall && !w_empty;

    // A full FIFO still accepts a push when an entry leaves on the same edge.
    assign w_push      = store && w_accepting && (!w_full || w_pop);
    assign w_drop      = store && !w_push;

    assign w_free      = DEPTH_C - r_count;

    // FIFO storage: no reset needed, occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= store_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_stall_out <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // ---------------- control FSM ----------------
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_addr  <= base_addr;
                        r_err   <= 1'b0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish only once nothing is buffered, nothing is in the
                    // output register and no late store is arriving now.
                    if (w_empty && !r_mem_req && !w_push) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_addr  <= base_addr;
                        r_done  <= 1'b0;
                    end
                end
            endcase

            // ---------------- FIFO pointers / occupancy ----------------
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end

            // ---------------- output register ----------------
            // Addresses are bound to entries as they leave the FIFO, so the
            // running address advances on each load rather than on each
            // completion; the resulting address sequence is identical.
            if (w_pop) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= r_addr;
                r_mem_data <= r_fifo[r_rd_ptr];
                r_addr     <= r_addr + ADDR_W'(8);
            end else if (w_xfer) begin
                r_mem_req  <= 1'b0;
            end

            // Reflects the occupancy seen this cycle, i.e. one edge late.
            r_stall_out <= (w_free <= MARGIN_C);

            // Set after the start-clear above so a dropped store still wins.
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef STORE_WRITER_COUNT_EN
    logic [31:0] r_written_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_written_count <= '0;
        end else if (start && ((r_state == IDLE) || (r_state == DONE))) begin
            r_written_count <= '0;
        end else if (w_xfer && (r_written_count != '1)) begin
            r_written_count <= r_written_count + 32'd1;
        end
    end

    assign written_count = r_written_count;
`endif

    assign stall_out = r_stall_out;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule
